// File: rtl/cosim_fifo_pkg.sv
// rtl/cosim_fifo_pkg.sv - Gray-code helpers shared by the cosim dual-clock FIFO
`timescale 1ns/1ps
package cosim_fifo_pkg;

  localparam int gray_max_w = 32;

  typedef logic [gray_max_w-1:0] gray_word_t;

  // Callers zero-extend narrower pointers; leading zeros are invariant under both conversions.
  function automatic gray_word_t bin2gray(input gray_word_t x);
    return x ^ (x >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t x);
    gray_word_t b;
    b[gray_max_w-1] = x[gray_max_w-1];
    for (int i = gray_max_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ x[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cosim_fifo_gray_sync.sv
// rtl/cosim_fifo_gray_sync.sv - Two-flop synchronizer with asynchronous active-low clear
`timescale 1ns/1ps
module cosim_fifo_gray_sync #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] meta_r;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      meta_r <= '0;
      q_o    <= '0;
    end else begin
      meta_r <= d_i;
      q_o    <= meta_r;
    end
  end

endmodule

// File: rtl/cosim_async_fifo.sv
// rtl/cosim_async_fifo.sv - Show-ahead dual-clock FIFO, core clock into cosim clock domain
// Optional protocol checks: define ASYNC_FIFO_ASSERT_EN.
`timescale 1ns/1ps
module cosim_async_fifo #(
  parameter int width_p   = 64,
  parameter int lg_size_p = 3
) (
  input  logic               cosim_clk_i,
  input  logic               reset_i,
  input  logic               w_clk_i,
  input  logic               w_enq_i,
  input  logic [width_p-1:0] w_data_i,
  output logic               w_full_o,
  input  logic               r_deq_i,
  output logic [width_p-1:0] r_data_o,
  output logic               r_valid_o
);

  import cosim_fifo_pkg::*;

  localparam int ptr_w = lg_size_p + 1;
  localparam int depth = 1 << lg_size_p;
  // Full when the pointers differ only in their two top Gray bits.
  localparam logic [ptr_w-1:0] full_mask = ptr_w'(3) << (ptr_w - 2);

  logic               w_rst_n;
  logic               r_rst_n;
  logic [ptr_w-1:0]   w_bin;
  logic [ptr_w-1:0]   w_gray;
  logic [ptr_w-1:0]   w_bin_next;
  logic [ptr_w-1:0]   r_bin;
  logic [ptr_w-1:0]   r_gray;
  logic [ptr_w-1:0]   r_bin_next;
  logic [ptr_w-1:0]   w_gray_rsync;
  logic [ptr_w-1:0]   r_gray_wsync;
  logic               w_push;
  logic               r_pop;
  logic [width_p-1:0] mem [depth];

  // Assertion is immediate in both domains; only deassertion is retimed.
  cosim_fifo_gray_sync #(.width_p(1)) u_w_rst_sync (
    .clk_i   (w_clk_i),
    .reset_i (reset_i),
    .d_i     (1'b1),
    .q_o     (w_rst_n)
  );

  cosim_fifo_gray_sync #(.width_p(1)) u_r_rst_sync (
    .clk_i   (cosim_clk_i),
    .reset_i (reset_i),
    .d_i     (1'b1),
    .q_o     (r_rst_n)
  );

  cosim_fifo_gray_sync #(.width_p(ptr_w)) u_wgray_to_r (
    .clk_i   (cosim_clk_i),
    .reset_i (r_rst_n),
    .d_i     (w_gray),
    .q_o     (w_gray_rsync)
  );

  cosim_fifo_gray_sync #(.width_p(ptr_w)) u_rgray_to_w (
    .clk_i   (w_clk_i),
    .reset_i (w_rst_n),
    .d_i     (r_gray),
    .q_o     (r_gray_wsync)
  );

  assign w_full_o   = (w_gray == (r_gray_wsync ^ full_mask));
  assign w_push     = w_enq_i & ~w_full_o & w_rst_n;
  assign w_bin_next = w_bin + 1'b1;

  always_ff @(posedge w_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_bin  <= '0;
      w_gray <= '0;
    end else if (w_push) begin
      w_bin  <= w_bin_next;
      w_gray <= ptr_w'(bin2gray(gray_word_t'(w_bin_next)));
    end
  end

  always_ff @(posedge w_clk_i) begin
    if (w_push) begin
      mem[w_bin[lg_size_p-1:0]] <= w_data_i;
    end
  end

  assign r_valid_o  = (r_gray != w_gray_rsync);
  assign r_data_o   = mem[r_bin[lg_size_p-1:0]];
  assign r_pop      = r_deq_i & r_valid_o;
  assign r_bin_next = r_bin + 1'b1;

  always_ff @(posedge cosim_clk_i or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else if (r_pop) begin
      r_bin  <= r_bin_next;
      r_gray <= ptr_w'(bin2gray(gray_word_t'(r_bin_next)));
    end
  end

`ifdef ASYNC_FIFO_ASSERT_EN
  always_ff @(posedge w_clk_i) begin
    if (reset_i && w_enq_i && w_full_o) begin
      $error("ASYNC_FIFO overflow");
    end
  end

  always_ff @(posedge cosim_clk_i) begin
    if (reset_i && r_deq_i && !r_valid_o) begin
      $error("ASYNC_FIFO underflow");
    end
  end
`else
  // Checks are left out of this build; the datapath is identical either way.
`endif

endmodule

// File: tb/tb_cosim_async_fifo.sv
// tb/tb_cosim_async_fifo.sv - Directed and table-driven bench for cosim_async_fifo
`timescale 1ns/1ps
module tb_cosim_async_fifo;

  logic       cosim_clk = 1'b0;
  logic       w_clk     = 1'b0;
  logic       reset_n   = 1'b1;
  logic       w_enq     = 1'b0;
  logic [7:0] w_data    = 8'h00;
  logic       w_full;
  logic       r_deq     = 1'b0;
  logic [7:0] r_data;
  logic       r_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       is_wr;
    logic [7:0] data;
    logic       exp_full;
  } step_t;

  step_t steps[9];

  cosim_async_fifo #(.width_p(8), .lg_size_p(2)) dut (
    .cosim_clk_i (cosim_clk),
    .reset_i     (reset_n),
    .w_clk_i     (w_clk),
    .w_enq_i     (w_enq),
    .w_data_i    (w_data),
    .w_full_o    (w_full),
    .r_deq_i     (r_deq),
    .r_data_o    (r_data),
    .r_valid_o   (r_valid)
  );

  always #5   w_clk     = ~w_clk;
  always #8.5 cosim_clk = ~cosim_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_step(input logic [7:0] d, input logic exp_full, input string nm);
    @(negedge w_clk);
    w_enq  = 1'b1;
    w_data = d;
    @(negedge w_clk);
    w_enq  = 1'b0;
    check(nm, 32'(w_full), 32'(exp_full));
  endtask

  task automatic read_step(input logic [7:0] exp, input string nm);
    int k;
    k = 0;
    @(negedge cosim_clk);
    while (!r_valid && k < 10) begin
      @(negedge cosim_clk);
      k++;
    end
    check({nm, "_valid"}, 32'(r_valid), 32'd1);
    if (r_valid) begin
      check(nm, 32'(r_data), 32'(exp));
      r_deq = 1'b1;
      @(negedge cosim_clk);
      r_deq = 1'b0;
    end
  endtask

  task automatic settle_empty(input string nm);
    repeat (6) @(negedge cosim_clk);
    check(nm, 32'(r_valid), 32'd0);
  endtask

  initial begin
    int edges;

    steps[0] = '{1'b1, 8'h01, 1'b0};
    steps[1] = '{1'b1, 8'h02, 1'b0};
    steps[2] = '{1'b1, 8'h03, 1'b0};
    steps[3] = '{1'b1, 8'h04, 1'b1};
    steps[4] = '{1'b1, 8'hFF, 1'b1};
    steps[5] = '{1'b0, 8'h01, 1'b0};
    steps[6] = '{1'b0, 8'h02, 1'b0};
    steps[7] = '{1'b0, 8'h03, 1'b0};
    steps[8] = '{1'b0, 8'h04, 1'b0};

    // 1: reset held with enqueue asserted
    #1 reset_n = 1'b0;
    w_enq  = 1'b1;
    w_data = 8'h77;
    repeat (3) @(negedge w_clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge w_clk);
      check("rst_full", 32'(w_full), 32'd0);
      check("rst_valid", 32'(r_valid), 32'd0);
    end
    w_enq = 1'b0;
    #2 reset_n = 1'b1;
    repeat (8) @(negedge w_clk);
    check("post_rst_full", 32'(w_full), 32'd0);
    settle_empty("post_rst_valid");

    // 2: single enqueue latency
    @(negedge w_clk);
    w_enq  = 1'b1;
    w_data = 8'hA5;
    @(posedge w_clk);
    #1 w_enq = 1'b0;
    edges = 0;
    while (!r_valid && edges < 6) begin
      @(posedge cosim_clk);
      #1 edges++;
    end
    check("a5_valid", 32'(r_valid), 32'd1);
    check("a5_latency_ok", 32'(edges <= 3), 32'd1);
    read_step(8'hA5, "a5_data");
    check("a5_empty", 32'(r_valid), 32'd0);

    // 3: fill to full, overflow dropped, drain
    for (int i = 0; i < 9; i++) begin
      if (steps[i].is_wr) write_step(steps[i].data, steps[i].exp_full, $sformatf("fill_full_%0d", i));
      else                read_step(steps[i].data, $sformatf("drain_%0d", i));
    end
    settle_empty("drain_empty");
    repeat (4) @(negedge w_clk);
    check("drain_full_released", 32'(w_full), 32'd0);

    // 4: random stream across many pointer wraps
    fork
      begin
        int sent = 0;
        int cyc  = 0;
        while (sent < 1000 && cyc < 40000) begin
          @(negedge w_clk);
          cyc++;
          if (!w_full && ($urandom % 4 != 0)) begin
            w_enq  = 1'b1;
            w_data = sent[7:0];
            sent++;
          end else begin
            w_enq = 1'b0;
          end
        end
        @(negedge w_clk);
        w_enq = 1'b0;
        check("stream_sent", sent, 1000);
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          @(negedge cosim_clk);
          cyc++;
          if (r_valid && ($urandom % 3 != 0)) begin
            check("stream_data", 32'(r_data), 32'(got[7:0]));
            r_deq = 1'b1;
            got++;
          end else begin
            r_deq = 1'b0;
          end
        end
        @(negedge cosim_clk);
        r_deq = 1'b0;
        check("stream_got", got, 1000);
      end
    join
    settle_empty("stream_empty");

    // 5: reset with entries queued
    write_step(8'h11, 1'b0, "rq_w0");
    write_step(8'h22, 1'b0, "rq_w1");
    write_step(8'h33, 1'b0, "rq_w2");
    edges = 0;
    while (!r_valid && edges < 10) begin
      @(negedge cosim_clk);
      edges++;
    end
    check("rq_valid", 32'(r_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rq_valid_now", 32'(r_valid), 32'd0);
    check("rq_full_now", 32'(w_full), 32'd0);
    #40 reset_n = 1'b1;
    repeat (6) @(negedge w_clk);
    check("rq_full_after", 32'(w_full), 32'd0);
    settle_empty("rq_empty_after");
    write_step(8'h3C, 1'b0, "rq_w_again");
    read_step(8'h3C, "rq_read_again");
    settle_empty("rq_final_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
